// File: rtl/cp0_pkg.sv
// Shared CP0 field positions, register indices and
// interrupt sequencer state encoding.
package cp0_pkg;

    localparam int STATUS_IE_BIT = 0;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_EXC_LSB = 2;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_TAKE,
        S_VEC,
        S_HANDLER,
        S_ERET_W
    } int_state_t;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// CP0 register-file side of the interrupt sequencer:
// INT entry write, rollback strobe and Status restore write.
interface cp0_int_ctrl_if;

    logic        int_out;
    logic [31:0] wepc;
    logic [31:0] wcause;
    logic [31:0] wstatus;
    logic        back;
    logic        c0w_req;
    logic [4:0]  c0w_addr;
    logic [31:0] c0w_data;

    modport master (
        output int_out, wepc, wcause, wstatus,
        output back, c0w_req, c0w_addr, c0w_data
    );

    modport slave (
        input int_out, wepc, wcause, wstatus,
        input back, c0w_req, c0w_addr, c0w_data
    );

endinterface

// File: rtl/cp0_irq_sample.sv
// Pending-interrupt register: masked irq sampled while idle,
// frozen for the rest of the entry/handler sequence.
module cp0_irq_sample #(
    parameter int NIRQ = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] im,
    input  logic            ie,
    input  logic            hold,
    output logic [NIRQ-1:0] pend,
    output logic            take
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else if (!hold) begin
            pend <= irq & im;
        end
    end

    assign take = (|pend) & ie;

endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt entry/return sequencer: drain, INT write,
// vector redirect, handler tracking and ERET restore.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int          NIRQ        = 6,
    parameter logic [31:0] VECTOR      = 32'h0000_0180,
    parameter logic [4:0]  STATUS_ADDR = 5'd12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     status,
    input  logic [31:0]     epc_cp0,
    input  logic [31:0]     epc_in,
    input  logic            drain_done,
    input  logic            eret,
    input  logic            squash,
    output logic            stall,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            in_handler,
    cp0_int_ctrl_if.master  c0
);

    int_state_t      state, nstate;
    logic [NIRQ-1:0] pend;
    logic            take;
    logic            hold;

    logic            n_stall, n_int, n_redir, n_inh, n_c0w;
    logic [31:0]     n_wepc, n_wcause, n_wstatus;
    logic [31:0]     n_c0w_data, n_rpc;

    assign hold = (state != S_IDLE);

    cp0_irq_sample #(.NIRQ(NIRQ)) u_sample (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .im   (status[STATUS_IM_LSB +: NIRQ]),
        .ie   (status[STATUS_IE_BIT]),
        .hold (hold),
        .pend (pend),
        .take (take)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:    if (take) nstate = S_DRAIN;
            S_DRAIN:   if (drain_done) nstate = S_TAKE;
            S_TAKE:    nstate = S_VEC;
            S_VEC:     nstate = S_HANDLER;
            S_HANDLER: if (eret) nstate = S_ERET_W;
            S_ERET_W:  nstate = S_IDLE;
            default:   nstate = S_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the next state.
    always_comb begin
        n_stall    = 1'b0;
        n_int      = 1'b0;
        n_redir    = 1'b0;
        n_inh      = 1'b0;
        n_c0w      = 1'b0;
        n_wepc     = '0;
        n_wcause   = '0;
        n_wstatus  = '0;
        n_c0w_data = '0;
        n_rpc      = '0;
        unique case (nstate)
            S_DRAIN: n_stall = 1'b1;
            S_TAKE: begin
                n_stall = 1'b1;
                n_int   = 1'b1;
                n_wepc  = epc_in;
                n_wcause[CAUSE_IP_LSB +: NIRQ] = pend;
                n_wstatus = status;
                n_wstatus[STATUS_IE_BIT] = 1'b0;
            end
            S_VEC: begin
                n_redir = 1'b1;
                n_rpc   = VECTOR;
            end
            S_HANDLER: n_inh = 1'b1;
            S_ERET_W: begin
                n_inh      = 1'b1;
                n_c0w      = 1'b1;
                n_c0w_data = status | 32'h1;
                n_redir    = 1'b1;
                n_rpc      = epc_cp0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            stall       <= 1'b0;
            c0.int_out  <= 1'b0;
            redirect    <= 1'b0;
            in_handler  <= 1'b0;
            c0.c0w_req  <= 1'b0;
            c0.wepc     <= '0;
            c0.wcause   <= '0;
            c0.wstatus  <= '0;
            c0.c0w_addr <= '0;
            c0.c0w_data <= '0;
            redirect_pc <= '0;
        end else begin
            state       <= nstate;
            stall       <= n_stall;
            c0.int_out  <= n_int;
            redirect    <= n_redir;
            in_handler  <= n_inh;
            c0.c0w_req  <= n_c0w;
            c0.wepc     <= n_wepc;
            c0.wcause   <= n_wcause;
            c0.wstatus  <= n_wstatus;
            c0.c0w_addr <= STATUS_ADDR;
            c0.c0w_data <= n_c0w_data;
            redirect_pc <= n_rpc;
        end
    end

    // INT already rolls back CP0 writes during entry.
    assign c0.back = squash & ((state == S_IDLE) |
                               (state == S_HANDLER) |
                               (state == S_ERET_W));

endmodule

// File: doc/cp0_int_ctrl.md
# cp0_int_ctrl

Interrupt sequencing controller for the CP0 register file. It samples external interrupt lines against the Status mask and stalls the pipeline until it drains. It then issues the single-cycle INT write (EPC/Cause/Status) that also triggers CP0 write rollback, and redirects fetch to the handler. It also handles ERET and arbitrates pipeline squash-rollback (`back`) requests against interrupt entry.

## Interface
Parameters:
- NIRQ, 6: number of interrupt lines (1..8), mapped to Status/Cause bits [8+NIRQ-1:8].
- VECTOR, 32'h0000_0180: handler entry address.
- STATUS_ADDR, 5'd12: CP0 index of Status, used for the ERET write.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- irq  in  NIRQ  level-sensitive interrupt requests.
- status  in  32  current CP0 Status: bit0 IE, bits[8+NIRQ-1:8] IM.
- epc_cp0  in  32  current CP0 EPC, used as the ERET target.
- epc_in  in  32  PC of the oldest unretired instruction, captured at entry.
- drain_done  in  1  pipeline reports it is empty while stalled.
- eret  in  1  single-cycle pulse when ERET reaches the CP0 stage.
- squash  in  1  pipeline request to roll back speculative CP0 writes.
- stall  out  1  freeze fetch/issue.
- int_out  out  1  drives c0rf INT, one-cycle pulse.
- wepc, wcause, wstatus  out  32  c0rf entry write data; valid while int_out=1.
- back  out  1  drives c0rf back, one-cycle pulse.
- c0w_req  out  1  CP0 write strobe (ERET Status restore).
- c0w_addr  out  5  always STATUS_ADDR.
- c0w_data  out  32  write data.
- redirect  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  redirect target.
- in_handler  out  1  high from entry until ERET completes.

## Operation
- pending register: `pend <= irq & status[8+NIRQ-1:8]`, updated every cycle in IDLE and frozen in other states. Take condition: `|pend && status[0]`.
- FSM states: IDLE, DRAIN, TAKE, VEC, HANDLER, ERET_W.
  - IDLE -> DRAIN on the take condition. stall=1 from DRAIN onward.
  - DRAIN -> TAKE when drain_done=1. DRAIN waits indefinitely.
  - TAKE: int_out=1. wepc=epc_in. wcause={16'b0, pend zero-extended to 8 bits, 8'b0}; ExcCode bits[6:2]=0. wstatus=status with bit0 cleared. Next state is VEC.
  - VEC: redirect=1, redirect_pc=VECTOR, stall released. Next state is HANDLER.
  - HANDLER: in_handler=1. Interrupts are not taken, because IE=0 and the state holds. eret=1 -> ERET_W.
  - ERET_W: c0w_req=1, c0w_data=status|1, redirect=1, redirect_pc=epc_cp0. Next state is IDLE. in_handler drops on entry to IDLE.
- back: back=squash only in IDLE, HANDLER and ERET_W. Suppressed in DRAIN/TAKE/VEC because INT performs the rollback itself.
- back and int_out are never both 1.
- All outputs are registered except back, which is combinational from squash gated by state.

## Timing
- Reset (rst=0): state IDLE, pend=0. stall, int_out, back, c0w_req, redirect and in_handler are 0. All data outputs are 0.
- irq asserted at edge N with IE=1: pend is set at N+1, stall=1 at N+2.
  - With drain_done already 1: int_out at N+3, redirect at N+4.
- irq deasserting after DRAIN entry does not abort. Cause reports the frozen pend.
- status[0] cleared while in DRAIN still completes the entry, which is already committed.
- eret outside HANDLER is ignored.
- squash and the take condition in the same IDLE cycle: back=1 that cycle and DRAIN is entered next cycle.
- rst asserted mid-sequence: immediate return to IDLE with all strobes 0. No partial INT is issued.

## Structure
- Shared package cp0_pkg holds STATUS_IE_BIT, STATUS_IM_LSB, CAUSE_IP_LSB, CAUSE_EXC_LSB, the CP0 index constants (12/13/14) and the FSM state encoding.
- One natural sub-module, cp0_irq_sample, contains the pending register and mask logic. The rest is a single FSM.

## Test plan
- Reset, then irq=6'b000100 with status=32'h0000_FF01 and drain_done=1: int_out pulse, wcause=32'h0000_0400, wstatus=32'h0000_FF00, redirect_pc=32'h180.
- Masked irq: status IM=0, irq=6'h3F for 20 cycles: stall and int_out stay 0.
- drain_done held low for 7 cycles after stall: int_out delayed exactly until 1 cycle after drain_done rises, and wepc equals epc_in at that cycle.
- ERET: in HANDLER with epc_cp0=32'h0040_0010 and eret pulse: next cycle c0w_req=1, c0w_addr=12, c0w_data=status|1, redirect_pc=32'h0040_0010, in_handler falls.
- squash during DRAIN gives back=0. squash in IDLE gives a same-cycle back=1.
- rst pulled low during TAKE: int_out and redirect 0 immediately. After release, the FSM is in IDLE and pend=0.
